// File: rtl/otter_pkg.sv
// Shared encodings for the OTTER control-unit decoder.
// Opcodes, mux selects, ALU codes and the decoded control bundle.
package otter_pkg;

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_IMM    = 7'b0010011,
    OPC_OP     = 7'b0110011,
    OPC_SYS    = 7'b1110011
  } opcode_t;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } br_f3_t;

  localparam logic [2:0] PC_PLUS4  = 3'd0;
  localparam logic [2:0] PC_JALR   = 3'd1;
  localparam logic [2:0] PC_BRANCH = 3'd2;
  localparam logic [2:0] PC_JAL    = 3'd3;
  localparam logic [2:0] PC_MTVEC  = 3'd4;
  localparam logic [2:0] PC_MEPC   = 3'd5;

  localparam logic [1:0] SRCA_RS1  = 2'd0;
  localparam logic [1:0] SRCA_UIMM = 2'd1;
  localparam logic [1:0] SRCA_NRS1 = 2'd2;

  localparam logic [2:0] SRCB_RS2  = 3'd0;
  localparam logic [2:0] SRCB_IIMM = 3'd1;
  localparam logic [2:0] SRCB_SIMM = 3'd2;
  localparam logic [2:0] SRCB_PC   = 3'd3;
  localparam logic [2:0] SRCB_CSR  = 3'd4;

  localparam logic [1:0] WR_PC4 = 2'd0;
  localparam logic [1:0] WR_CSR = 2'd1;
  localparam logic [1:0] WR_MEM = 2'd2;
  localparam logic [1:0] WR_ALU = 2'd3;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0111;
  localparam logic [3:0] ALU_LUI = 4'b1001;

  localparam logic [31:0] MRET_INSN = 32'h30200073;

  typedef struct packed {
    logic [3:0] alu_fun;
    logic [1:0] alu_srcA;
    logic [2:0] alu_srcB;
    logic [2:0] pcSource;
    logic [1:0] rf_wr_sel;
    logic       regWrite;
    logic       memWE;
    logic       memRDEN;
    logic       csrWE;
    logic       mret;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/cu_dcdr_comb.sv
// Pure combinational RV32I(+Zicsr) decode into the control bundle.
// Branches resolve here from the same-cycle compare flags.
module cu_dcdr_comb
  import otter_pkg::*;
#(
  parameter bit CSR_EN       = 1'b1,
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic [31:0] ir,
  input  logic        br_eq,
  input  logic        br_lt,
  input  logic        br_ltu,
  output ctrl_t       ctrl
);

  logic [2:0] f3;
  logic [6:0] f7;
  logic       take;
  logic       bad;
  ctrl_t      c;

  always_comb begin
    f3   = ir[14:12];
    f7   = ir[31:25];
    c    = '0;
    take = 1'b0;
    bad  = 1'b0;
    case (opcode_t'(ir[6:0]))
      OPC_LUI: begin
        c.alu_srcA  = SRCA_UIMM;
        c.alu_fun   = ALU_LUI;
        c.rf_wr_sel = WR_ALU;
        c.regWrite  = 1'b1;
      end
      OPC_AUIPC: begin
        c.alu_srcA  = SRCA_UIMM;
        c.alu_srcB  = SRCB_PC;
        c.alu_fun   = ALU_ADD;
        c.rf_wr_sel = WR_ALU;
        c.regWrite  = 1'b1;
      end
      OPC_JAL: begin
        c.pcSource  = PC_JAL;
        c.rf_wr_sel = WR_PC4;
        c.regWrite  = 1'b1;
      end
      OPC_JALR: begin
        c.pcSource  = PC_JALR;
        c.rf_wr_sel = WR_PC4;
        c.regWrite  = 1'b1;
      end
      OPC_BRANCH: begin
        case (br_f3_t'(f3))
          F3_BEQ:  take = br_eq;
          F3_BNE:  take = !br_eq;
          F3_BLT:  take = br_lt;
          F3_BGE:  take = !br_lt;
          F3_BLTU: take = br_ltu;
          F3_BGEU: take = !br_ltu;
          default: bad  = 1'b1;
        endcase
        c.pcSource = take ? PC_BRANCH : PC_PLUS4;
      end
      OPC_LOAD: begin
        c.alu_srcB  = SRCB_IIMM;
        c.alu_fun   = ALU_ADD;
        c.memRDEN   = 1'b1;
        c.rf_wr_sel = WR_MEM;
        c.regWrite  = 1'b1;
      end
      OPC_STORE: begin
        c.alu_srcB = SRCB_SIMM;
        c.alu_fun  = ALU_ADD;
        c.memWE    = 1'b1;
      end
      OPC_IMM: begin
        if (f3 == 3'b001 && f7 != 7'h00)
          bad = 1'b1;
        if (f3 == 3'b101 && f7 != 7'h00
            && f7 != 7'h20)
          bad = 1'b1;
        c.alu_srcB  = SRCB_IIMM;
        c.alu_fun   = {ir[30] & (f3 == 3'b101), f3};
        c.rf_wr_sel = WR_ALU;
        c.regWrite  = 1'b1;
      end
      OPC_OP: begin
        if (f7 == 7'h20)
          bad = !(f3 == 3'b000 || f3 == 3'b101);
        else if (f7 != 7'h00)
          bad = 1'b1;
        c.alu_srcB  = SRCB_RS2;
        c.alu_fun   = {ir[30], f3};
        c.rf_wr_sel = WR_ALU;
        c.regWrite  = 1'b1;
      end
      OPC_SYS: begin
        if (!CSR_EN) begin
          bad = 1'b1;
        end else if (ir == MRET_INSN) begin
          c.pcSource = PC_MEPC;
          c.mret     = 1'b1;
        end else begin
          unique case (1'b1)
            (f3 == 3'b000): bad = 1'b1;
            (f3 == 3'b001): c.alu_fun = ALU_LUI;
            (f3 == 3'b010): begin
              c.alu_srcB = SRCB_CSR;
              c.alu_fun  = ALU_OR;
            end
            (f3 == 3'b011): begin
              c.alu_srcA = SRCA_NRS1;
              c.alu_srcB = SRCB_CSR;
              c.alu_fun  = ALU_AND;
            end
            default: ;
          endcase
          if (f3 != 3'b000 && !f3[2]) begin
            c.rf_wr_sel = WR_CSR;
            c.csrWE     = 1'b1;
            c.regWrite  = 1'b1;
          end
        end
      end
      default: bad = 1'b1;
    endcase
    // illegal instructions never write anything
    if (bad) begin
      c          = '0;
      c.illegal  = 1'b1;
      c.pcSource = ILLEGAL_TRAP ? PC_MTVEC
                                : PC_PLUS4;
    end
    ctrl = c;
  end

endmodule

// File: rtl/cu_dcdr_pipe.sv
// Registered decoder stage with a 2-entry skid buffer
// and saturating retired/taken counters.
module cu_dcdr_pipe
  import otter_pkg::*;
#(
  parameter bit          CSR_EN       = 1'b1,
  parameter bit          ILLEGAL_TRAP = 1'b1,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      ir,
  input  logic             br_eq,
  input  logic             br_lt,
  input  logic             br_ltu,
  input  logic             flush,
  input  logic             cnt_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       alu_fun,
  output logic [1:0]       alu_srcA,
  output logic [2:0]       alu_srcB,
  output logic [2:0]       pcSource,
  output logic [1:0]       rf_wr_sel,
  output logic             regWrite,
  output logic             memWE,
  output logic             memRDEN,
  output logic             csrWE,
  output logic             mret,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [CNT_W-1:0] CONE =
    {{(CNT_W-1){1'b0}}, 1'b1};

  ctrl_t dec;
  ctrl_t out_q, out_d;
  ctrl_t skid_q, skid_d;
  logic  ov_q, ov_d;
  logic  sv_q, sv_d;
  logic  acc, hs;
  logic [CNT_W-1:0] icnt_q, icnt_d;
  logic [CNT_W-1:0] tcnt_q, tcnt_d;

  cu_dcdr_comb #(
    .CSR_EN      (CSR_EN),
    .ILLEGAL_TRAP(ILLEGAL_TRAP)
  ) u_comb (
    .ir    (ir),
    .br_eq (br_eq),
    .br_lt (br_lt),
    .br_ltu(br_ltu),
    .ctrl  (dec)
  );

  assign in_ready = !sv_q;
  assign acc      = in_valid & !sv_q;
  assign hs       = ov_q & out_ready;

  always_comb begin
    out_d  = out_q;
    skid_d = skid_q;
    ov_d   = ov_q;
    sv_d   = sv_q;
    if (hs) begin
      if (sv_q) begin
        out_d = skid_q;
        sv_d  = 1'b0;
      end else if (acc) begin
        out_d = dec;
      end else begin
        ov_d = 1'b0;
      end
    end else if (!ov_q) begin
      if (acc) begin
        out_d = dec;
        ov_d  = 1'b1;
      end
    end else if (acc) begin
      skid_d = dec;
      sv_d   = 1'b1;
    end
    if (flush) begin
      ov_d = 1'b0;
      sv_d = 1'b0;
    end
  end

  always_comb begin
    icnt_d = icnt_q;
    tcnt_d = tcnt_q;
    if (hs && icnt_q != CMAX)
      icnt_d = icnt_q + CONE;
    if (hs && out_q.pcSource == PC_BRANCH
        && tcnt_q != CMAX)
      tcnt_d = tcnt_q + CONE;
    if (cnt_clr) begin
      icnt_d = '0;
      tcnt_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      out_q  <= '0;
      skid_q <= '0;
      ov_q   <= 1'b0;
      sv_q   <= 1'b0;
      icnt_q <= '0;
      tcnt_q <= '0;
    end else begin
      out_q  <= out_d;
      skid_q <= skid_d;
      ov_q   <= ov_d;
      sv_q   <= sv_d;
      icnt_q <= icnt_d;
      tcnt_q <= tcnt_d;
    end
  end

  assign out_valid = ov_q;
  assign alu_fun   = out_q.alu_fun;
  assign alu_srcA  = out_q.alu_srcA;
  assign alu_srcB  = out_q.alu_srcB;
  assign pcSource  = out_q.pcSource;
  assign rf_wr_sel = out_q.rf_wr_sel;
  assign regWrite  = out_q.regWrite;
  assign memWE     = out_q.memWE;
  assign memRDEN   = out_q.memRDEN;
  assign csrWE     = out_q.csrWE;
  assign mret      = out_q.mret;
  assign illegal   = out_q.illegal;
  assign instr_cnt = icnt_q;
  assign taken_cnt = tcnt_q;

endmodule

// File: tb/tb_cu_dcdr_pipe.sv
// Scoreboard bench for cu_dcdr_pipe: a default instance and a
// CSR-less, 8-bit-counter instance share the same stimulus.
`timescale 1ns/1ps
module tb_cu_dcdr_pipe;
  import otter_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        in_valid;
  logic [31:0] ir;
  logic        br_eq, br_lt, br_ltu;
  logic        flush, cnt_clr, out_ready;

  logic        in_ready_a, out_valid_a;
  logic [3:0]  alu_fun_a;
  logic [1:0]  alu_srcA_a, rf_wr_sel_a;
  logic [2:0]  alu_srcB_a, pcSource_a;
  logic        regWrite_a, memWE_a, memRDEN_a;
  logic        csrWE_a, mret_a, illegal_a;
  logic [31:0] instr_cnt_a, taken_cnt_a;

  logic        in_ready_b, out_valid_b;
  logic [3:0]  alu_fun_b;
  logic [1:0]  alu_srcA_b, rf_wr_sel_b;
  logic [2:0]  alu_srcB_b, pcSource_b;
  logic        regWrite_b, memWE_b, memRDEN_b;
  logic        csrWE_b, mret_b, illegal_b;
  logic [7:0]  instr_cnt_b, taken_cnt_b;

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  typedef struct {
    ctrl_t a;
    ctrl_t b;
  } exp_t;
  exp_t sb[$];

  logic [31:0] ei_a, et_a;
  logic [7:0]  ei_b, et_b;

  always #5 CLK = ~CLK;

  cu_dcdr_pipe dut_a (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready_a),
    .ir(ir), .br_eq(br_eq), .br_lt(br_lt),
    .br_ltu(br_ltu), .flush(flush),
    .cnt_clr(cnt_clr), .out_valid(out_valid_a),
    .out_ready(out_ready), .alu_fun(alu_fun_a),
    .alu_srcA(alu_srcA_a), .alu_srcB(alu_srcB_a),
    .pcSource(pcSource_a), .rf_wr_sel(rf_wr_sel_a),
    .regWrite(regWrite_a), .memWE(memWE_a),
    .memRDEN(memRDEN_a), .csrWE(csrWE_a),
    .mret(mret_a), .illegal(illegal_a),
    .instr_cnt(instr_cnt_a), .taken_cnt(taken_cnt_a)
  );

  cu_dcdr_pipe #(
    .CSR_EN(1'b0), .ILLEGAL_TRAP(1'b1), .CNT_W(8)
  ) dut_b (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready_b),
    .ir(ir), .br_eq(br_eq), .br_lt(br_lt),
    .br_ltu(br_ltu), .flush(flush),
    .cnt_clr(cnt_clr), .out_valid(out_valid_b),
    .out_ready(out_ready), .alu_fun(alu_fun_b),
    .alu_srcA(alu_srcA_b), .alu_srcB(alu_srcB_b),
    .pcSource(pcSource_b), .rf_wr_sel(rf_wr_sel_b),
    .regWrite(regWrite_b), .memWE(memWE_b),
    .memRDEN(memRDEN_b), .csrWE(csrWE_b),
    .mret(mret_b), .illegal(illegal_b),
    .instr_cnt(instr_cnt_b), .taken_cnt(taken_cnt_b)
  );

  ctrl_t pk_a, pk_b;
  always_comb begin
    pk_a = {alu_fun_a, alu_srcA_a, alu_srcB_a,
            pcSource_a, rf_wr_sel_a, regWrite_a,
            memWE_a, memRDEN_a, csrWE_a, mret_a,
            illegal_a};
    pk_b = {alu_fun_b, alu_srcA_b, alu_srcB_b,
            pcSource_b, rf_wr_sel_b, regWrite_b,
            memWE_b, memRDEN_b, csrWE_b, mret_b,
            illegal_b};
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // reference decode, written from the instruction-set rules
  function automatic ctrl_t ref_dec(
      input logic [31:0] i, input logic eq,
      input logic lt, input logic ltu,
      input bit csr, input bit trap);
    ctrl_t c;
    logic [6:0] op, f7;
    logic [2:0] f3;
    bit b, tk;
    c = '0; b = 0;
    op = i[6:0]; f3 = i[14:12]; f7 = i[31:25];
    if (op == 7'h37) begin
      c.alu_srcA = 1; c.alu_fun = 4'd9;
      c.rf_wr_sel = 3; c.regWrite = 1;
    end else if (op == 7'h17) begin
      c.alu_srcA = 1; c.alu_srcB = 3;
      c.rf_wr_sel = 3; c.regWrite = 1;
    end else if (op == 7'h6f) begin
      c.pcSource = 3; c.regWrite = 1;
    end else if (op == 7'h67) begin
      c.pcSource = 1; c.regWrite = 1;
    end else if (op == 7'h63) begin
      if (f3 == 2 || f3 == 3) b = 1;
      else begin
        tk = !f3[2] ? eq : (f3[1] ? ltu : lt);
        if (f3[0]) tk = !tk;
        c.pcSource = tk ? 3'd2 : 3'd0;
      end
    end else if (op == 7'h03) begin
      c.alu_srcB = 1; c.memRDEN = 1;
      c.rf_wr_sel = 2; c.regWrite = 1;
    end else if (op == 7'h23) begin
      c.alu_srcB = 2; c.memWE = 1;
    end else if (op == 7'h13) begin
      if (f3 == 1 && f7 != 0) b = 1;
      if (f3 == 5 && f7 != 0 && f7 != 7'h20) b = 1;
      c.alu_srcB = 1;
      c.alu_fun = {(f3 == 5) && i[30], f3};
      c.rf_wr_sel = 3; c.regWrite = 1;
    end else if (op == 7'h33) begin
      if (!(f7 == 0 ||
            (f7 == 7'h20 && (f3 == 0 || f3 == 5))))
        b = 1;
      c.alu_fun = {i[30], f3};
      c.rf_wr_sel = 3; c.regWrite = 1;
    end else if (op == 7'h73) begin
      if (!csr) b = 1;
      else if (i == 32'h30200073) begin
        c.pcSource = 5; c.mret = 1;
      end else if (f3 == 0) b = 1;
      else if (f3 <= 3) begin
        c.rf_wr_sel = 1; c.csrWE = 1; c.regWrite = 1;
        if (f3 == 1) c.alu_fun = 4'd9;
        if (f3 == 2) begin
          c.alu_srcB = 4; c.alu_fun = 4'd6;
        end
        if (f3 == 3) begin
          c.alu_srcA = 2; c.alu_srcB = 4;
          c.alu_fun = 4'd7;
        end
      end
    end else b = 1;
    if (b) begin
      c = '0; c.illegal = 1;
      c.pcSource = trap ? 3'd4 : 3'd0;
    end
    return c;
  endfunction

  function automatic logic [31:0] rnd_ir();
    logic [31:0] i;
    i = $urandom;
    case ($urandom_range(0, 12))
      0: i[6:0] = 7'h37;
      1: i[6:0] = 7'h17;
      2: i[6:0] = 7'h6f;
      3: i[6:0] = 7'h67;
      4: i[6:0] = 7'h63;
      5: i[6:0] = 7'h03;
      6: i[6:0] = 7'h23;
      7: begin
        i[6:0] = 7'h13;
        i[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
      end
      8: begin
        i[6:0] = 7'h33;
        i[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
      end
      9: i[6:0] = 7'h73;
      10: i = 32'h30200073;
      11: i[6:0] = $urandom_range(0, 1) ? 7'h13 : 7'h33;
      default: ;
    endcase
    return i;
  endfunction

  // monitor: checks the outputs presented this cycle, then
  // applies the coming edge to the expected state
  always @(negedge CLK) begin
    if (mon_en) begin
      chk("out_valid_a", 64'(out_valid_a), 64'(sb.size() > 0));
      chk("out_valid_b", 64'(out_valid_b), 64'(sb.size() > 0));
      chk("in_ready_a", 64'(in_ready_a), 64'(sb.size() < 2));
      chk("in_ready_b", 64'(in_ready_b), 64'(sb.size() < 2));
      chk("instr_cnt_a", 64'(instr_cnt_a), 64'(ei_a));
      chk("taken_cnt_a", 64'(taken_cnt_a), 64'(et_a));
      chk("instr_cnt_b", 64'(instr_cnt_b), 64'(ei_b));
      chk("taken_cnt_b", 64'(taken_cnt_b), 64'(et_b));
      if (sb.size() > 0) begin
        chk("ctrl_a", 64'(pk_a), 64'(sb[0].a));
        chk("ctrl_b", 64'(pk_b), 64'(sb[0].b));
        if (out_ready) begin
          exp_t e;
          e = sb.pop_front();
          if (ei_a != 32'hFFFF_FFFF) ei_a++;
          if (ei_b != 8'hFF) ei_b++;
          if (e.a.pcSource == 3'd2 && et_a != 32'hFFFF_FFFF)
            et_a++;
          if (e.b.pcSource == 3'd2 && et_b != 8'hFF)
            et_b++;
        end
      end
      if (cnt_clr) begin
        ei_a = 0; et_a = 0; ei_b = 0; et_b = 0;
      end
    end
  end

  task automatic cyc(input logic v, input logic [31:0] i,
                     input logic [2:0] fl, input logic ordy,
                     input logic fls, input logic clr);
    in_valid = v; ir = i;
    {br_eq, br_lt, br_ltu} = fl;
    out_ready = ordy; flush = fls; cnt_clr = clr;
    @(negedge CLK);
    #2;
    if (fls) sb.delete();
    else if (v && in_ready_a)
      sb.push_back('{a: ref_dec(i, fl[2], fl[1], fl[0], 1, 1),
                     b: ref_dec(i, fl[2], fl[1], fl[0], 0, 1)});
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 1, 0, 0);
  endtask

  ctrl_t x;

  initial begin
    RST = 1; in_valid = 0; ir = 0;
    br_eq = 0; br_lt = 0; br_ltu = 0;
    flush = 0; cnt_clr = 0; out_ready = 0;
    ei_a = 0; et_a = 0; ei_b = 0; et_b = 0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 0;
    chk("rst_ctrl_a", 64'(pk_a), 64'd0);
    chk("rst_ctrl_b", 64'(pk_b), 64'd0);
    mon_en = 1;
    cyc(0, 0, 0, 0, 0, 0);

    // addi x1,x0,5
    cyc(1, 32'h00500093, 0, 1, 0, 0);
    x = '0; x.alu_srcB = 1; x.rf_wr_sel = 3; x.regWrite = 1;
    chk("addi_valid", 64'(out_valid_a), 64'd1);
    chk("addi_ctrl", 64'(pk_a), 64'(x));
    // handshake and clear on the same edge
    cyc(0, 0, 0, 1, 0, 1);
    chk("clr_hs_instr", 64'(instr_cnt_a), 64'd0);

    // beq / bne with eq set
    cyc(1, 32'h00208063, 3'b100, 1, 0, 0);
    chk("beq_pc", 64'(pcSource_a), 64'd2);
    cyc(1, 32'h00209063, 3'b100, 1, 0, 0);
    chk("bne_pc", 64'(pcSource_a), 64'd0);
    idle(2);
    chk("br_instr", 64'(instr_cnt_a), 64'd2);
    chk("br_taken", 64'(taken_cnt_a), 64'd1);

    // backpressure: third offer must be refused
    cyc(1, rnd_ir(), 3'($urandom), 0, 0, 0);
    cyc(1, rnd_ir(), 3'($urandom), 0, 0, 0);
    chk("bp_in_ready", 64'(in_ready_a), 64'd0);
    cyc(1, rnd_ir(), 3'($urandom), 0, 0, 0);
    idle(3);
    chk("bp_drain", 64'(out_valid_a), 64'd0);
    chk("bp_cnt", 64'(instr_cnt_a), 64'd4);

    // illegal word and mret on the CSR-less instance
    x = '0; x.illegal = 1; x.pcSource = 4;
    cyc(1, 32'hFFFFFFFF, 0, 1, 0, 0);
    chk("ill_ff_b", 64'(pk_b), 64'(x));
    chk("ill_ff_a", 64'(pk_a), 64'(x));
    cyc(1, 32'h30200073, 0, 1, 0, 0);
    chk("ill_mret_b", 64'(pk_b), 64'(x));
    x = '0; x.pcSource = 5; x.mret = 1;
    chk("mret_a", 64'(pk_a), 64'(x));
    idle(1);

    // flush with both stages full and a live offer
    cyc(1, rnd_ir(), 0, 0, 0, 0);
    cyc(1, rnd_ir(), 0, 0, 0, 0);
    chk("fl_pre_cnt", 64'(instr_cnt_a), 64'd6);
    cyc(1, rnd_ir(), 0, 0, 1, 0);
    chk("fl_ov", 64'(out_valid_a), 64'd0);
    chk("fl_ir", 64'(in_ready_a), 64'd1);
    idle(2);
    chk("fl_cnt", 64'(instr_cnt_a), 64'd6);

    // counter saturation on the 8-bit instance
    cyc(0, 0, 0, 1, 0, 1);
    for (int k = 0; k < 300; k++)
      cyc(1, rnd_ir(), 3'($urandom), 1, 0, 0);
    idle(2);
    chk("sat_b", 64'(instr_cnt_b), 64'd255);
    chk("nosat_a", 64'(instr_cnt_a), 64'd300);

    // random traffic
    for (int k = 0; k < 3000; k++)
      cyc(1'($urandom_range(0, 3) != 0), rnd_ir(),
          3'($urandom), 1'($urandom_range(0, 9) < 7),
          1'($urandom_range(0, 49) == 0),
          1'($urandom_range(0, 49) == 0));
    idle(4);
    chk("final_empty", 64'(out_valid_a), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
